// File: rtl/imem_loader_if.sv
// Byte-stream receive side and imem write port of the boot loader, bundled together.
// The loader takes the slave view; the host/link and imem side take the master view.
interface imem_loader_if #(
   parameter int ADDR_W = 15
) ();
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time imem loader: parses MAGIC/LEN/data/SUM frames, packs bytes big-endian into
// words, writes imem and releases the core from reset only after a good checksum.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_MAGIC  | hunting for the frame start byte, other bytes discarded
// S_LEN_HI | expecting word count [15:8]
// S_LEN_LO | expecting word count [7:0], range check against IMEM_SIZE
// S_DATA   | packing data bytes, one imem write per 4 bytes
// S_SUM    | expecting checksum byte
// S_DONE   | frame good, core released, waiting for reload
// S_ERR    | overflow or bad checksum, core held, waiting for reload
module imem_loader #(
   parameter int         IMEM_SIZE = 32768,
   parameter logic [7:0] MAGIC     = 8'hA5
) (
   input  logic          clk,
   input  logic          reset_n,
   imem_loader_if.slave  bus,
   input  logic          reload,
   output logic          core_reset_n,
   output logic          load_done,
   output logic          load_error,
   output logic [15:0]   word_count
);
   localparam int ADDR_W = $clog2(IMEM_SIZE);

   typedef enum logic [2:0] {
      S_MAGIC, S_LEN_HI, S_LEN_LO, S_DATA, S_SUM, S_DONE, S_ERR
   } state_t;

   state_t            r_state;
   logic [7:0]        r_len_hi;
   logic [15:0]       r_words_left;
   logic [7:0]        r_acc;
   logic [1:0]        r_byte_idx;
   logic [23:0]       r_shift;
   logic [15:0]       r_word_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_core_rst_n;
   logic              r_done;
   logic              r_err;

   logic              w_ready;
   logic              w_accept;
   logic [15:0]       w_len;
   logic              w_len_big;
   logic [7:0]        w_sum;

   assign w_ready   = (r_state != S_DONE) && (r_state != S_ERR);
   assign w_accept  = bus.rx_valid && w_ready;
   assign w_len     = {r_len_hi, bus.rx_data};
   assign w_len_big = {16'h0000, w_len} > 32'(IMEM_SIZE);
   assign w_sum     = r_acc + bus.rx_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_MAGIC;
         r_len_hi     <= 8'h00;
         r_words_left <= 16'h0000;
         r_acc        <= 8'h00;
         r_byte_idx   <= 2'd0;
         r_shift      <= 24'h000000;
         r_word_cnt   <= 16'h0000;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= 32'h0000_0000;
         r_core_rst_n <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_MAGIC: begin
               if (w_accept && (bus.rx_data == MAGIC)) r_state <= S_LEN_HI;
            end
            S_LEN_HI: begin
               if (w_accept) begin
                  r_len_hi <= bus.rx_data;
                  r_state  <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (w_accept) begin
                  r_acc        <= 8'h00;
                  r_word_cnt   <= 16'h0000;
                  r_byte_idx   <= 2'd0;
                  r_words_left <= w_len;
                  if (w_len_big) begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end else if (w_len == 16'h0000) begin
                     r_state <= S_SUM;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_acc      <= w_sum;
                  r_shift    <= {r_shift[15:0], bus.rx_data};
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     r_we         <= 1'b1;
                     r_addr       <= r_word_cnt[ADDR_W-1:0];
                     r_wdata      <= {r_shift, bus.rx_data};
                     r_word_cnt   <= r_word_cnt + 16'd1;
                     r_words_left <= r_words_left - 16'd1;
                     if (r_words_left == 16'd1) r_state <= S_SUM;
                  end
               end
            end
            S_SUM: begin
               if (w_accept) begin
                  if (w_sum == 8'h00) begin
                     r_state      <= S_DONE;
                     r_done       <= 1'b1;
                     r_core_rst_n <= 1'b1;
                  end else begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_DONE, S_ERR: begin
               if (reload) begin
                  r_state      <= S_MAGIC;
                  r_done       <= 1'b0;
                  r_err        <= 1'b0;
                  r_core_rst_n <= 1'b0;
                  r_word_cnt   <= 16'h0000;
                  r_acc        <= 8'h00;
               end
            end
            default: r_state <= S_MAGIC;
         endcase
      end
   end

   assign bus.rx_ready   = w_ready;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign core_reset_n   = r_core_rst_n;
   assign load_done      = r_done;
   assign load_error     = r_err;
   assign word_count     = r_word_cnt;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected imem writes are queued as frames are sent
// and checked by a write monitor; status outputs are checked after each frame.
module tb_imem_loader;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        reload = 1'b0;
   logic        core_reset_n;
   logic        load_done;
   logic        load_error;
   logic [15:0] word_count;

   imem_loader_if #(.ADDR_W(15)) bus ();

   imem_loader dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .reload       (reload),
      .core_reset_n (core_reset_n),
      .load_done    (load_done),
      .load_error   (load_error),
      .word_count   (word_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [14:0] addr;
      logic [31:0] data;
   } wr_t;

   int          checks = 0;
   int          failures = 0;
   int          n_writes = 0;
   int          base_writes;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [31:0] frame_words[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && bus.imem_we) begin
         n_writes++;
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_write observed addr=%h data=%h expected no write",
                   bus.imem_addr, bus.imem_wdata);
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(bus.imem_addr), 32'(mon_e.addr));
            check("wr_data", bus.imem_wdata, mon_e.data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) while ($urandom_range(1, 0) == 1) @(negedge clk);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      n = 0;
      while (!bus.rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", 32'(bus.rx_ready), 32'd1);
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input bit bad_sum, input bit gaps);
      logic [7:0] s;
      logic [7:0] bt;
      logic [7:0] sb;
      logic [31:0] w;
      int n;
      s = 8'h00;
      n = frame_words.size();
      send_byte(8'hA5, gaps);
      send_byte(8'(n >> 8), gaps);
      send_byte(8'(n), gaps);
      for (int i = 0; i < n; i++) begin
         w = frame_words[i];
         exp_q.push_back({15'(i), w});
         for (int k = 0; k < 4; k++) begin
            bt = w[31 - 8*k -: 8];
            s  = s + bt;
            send_byte(bt, gaps);
         end
      end
      sb = 8'h00 - s;
      if (bad_sum) sb = sb + 8'h01;
      send_byte(sb, gaps);
   endtask

   task automatic wait_end(input string tag, input bit exp_done);
      int n;
      n = 0;
      @(negedge clk);
      while (!(load_done || load_error) && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, 32'(load_done), 32'(exp_done));
      check({tag, "_error"}, 32'(load_error), 32'(!exp_done));
      check({tag, "_core_reset_n"}, 32'(core_reset_n), 32'(exp_done));
      check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
      check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic pulse_reload(input string tag);
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      check({tag, "_rl_rx_ready"}, 32'(bus.rx_ready), 32'd1);
      check({tag, "_rl_done"}, 32'(load_done), 32'd0);
      check({tag, "_rl_error"}, 32'(load_error), 32'd0);
      check({tag, "_rl_core_reset_n"}, 32'(core_reset_n), 32'd0);
      check({tag, "_rl_word_count"}, 32'(word_count), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
      check({tag, "_we"}, 32'(bus.imem_we), 32'd0);
      check({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
      check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
      check({tag, "_core_reset_n"}, 32'(core_reset_n), 32'd0);
      check({tag, "_done"}, 32'(load_done), 32'd0);
      check({tag, "_error"}, 32'(load_error), 32'd0);
      check({tag, "_word_count"}, 32'(word_count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      #2;
      check_reset_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // single word, good checksum
      frame_words = {32'hDEADBEEF};
      base_writes = n_writes;
      send_frame(1'b0, 1'b0);
      wait_end("t1", 1'b1);
      check("t1_writes", 32'(n_writes - base_writes), 32'd1);
      check("t1_word_count", 32'(word_count), 32'd1);
      pulse_reload("t1");

      // junk before MAGIC, empty frame
      base_writes = n_writes;
      send_byte(8'h00, 1'b0);
      send_byte(8'hFF, 1'b0);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      wait_end("t2", 1'b1);
      check("t2_writes", 32'(n_writes - base_writes), 32'd0);
      check("t2_word_count", 32'(word_count), 32'd0);
      pulse_reload("t2");

      // two words, checksum off by one
      frame_words = {32'h01234567, 32'h89ABCDEF};
      base_writes = n_writes;
      send_frame(1'b1, 1'b0);
      wait_end("t3", 1'b0);
      check("t3_writes", 32'(n_writes - base_writes), 32'd2);
      check("t3_word_count", 32'(word_count), 32'd2);
      pulse_reload("t3");

      // length overflow
      base_writes = n_writes;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h80, 1'b0);
      send_byte(8'h01, 1'b0);
      wait_end("t4", 1'b0);
      check("t4_writes", 32'(n_writes - base_writes), 32'd0);
      pulse_reload("t4");

      // 16 words with random valid gaps
      frame_words.delete();
      for (int i = 0; i < 16; i++) frame_words.push_back($urandom());
      base_writes = n_writes;
      send_frame(1'b0, 1'b1);
      wait_end("t5", 1'b1);
      check("t5_writes", 32'(n_writes - base_writes), 32'd16);
      check("t5_word_count", 32'(word_count), 32'd16);
      pulse_reload("t5");

      // reset mid-frame after 6 data bytes, then a fresh frame
      base_writes = n_writes;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h04, 1'b0);
      exp_q.push_back({15'd0, 32'hCAFEF00D});
      send_byte(8'hCA, 1'b0);
      send_byte(8'hFE, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h0D, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      check_reset_outputs("t6_rst");
      check("t6_partial_writes", 32'(n_writes - base_writes), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      frame_words = {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C};
      base_writes = n_writes;
      send_frame(1'b0, 1'b0);
      wait_end("t6", 1'b1);
      check("t6_writes", 32'(n_writes - base_writes), 32'd3);
      check("t6_word_count", 32'(word_count), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
